// File: rtl/spatz_vrf_writer_pkg.sv
// Shared types and geometry for the spatz VRF write-side requesters.
// The vector register file is addressed as vreg * NrWordsPerVreg + word, bank field in the LSBs.
package spatz_vrf_writer_pkg;

  localparam int unsigned VLEN    = 512;
  localparam int unsigned N_IPU   = 2;
  localparam int unsigned ELEN    = 64;
  localparam int unsigned NrVregs = 32;

  localparam int unsigned NrWordsPerVreg = VLEN / (N_IPU * ELEN);
  localparam int unsigned MaxWords       = 8 * NrWordsPerVreg;
  localparam int unsigned NWordsWidth    = $clog2(MaxWords + 1);

  localparam int unsigned VregDataWidth = N_IPU * ELEN;
  localparam int unsigned VregBeWidth   = VregDataWidth / 8;
  localparam int unsigned VregAddrWidth = $clog2(NrVregs * NrWordsPerVreg);

  typedef logic [VregAddrWidth-1:0] vreg_addr_t;
  typedef logic [VregDataWidth-1:0] vreg_data_t;
  typedef logic [VregBeWidth-1:0]   vreg_be_t;

  typedef struct packed {
    logic [4:0]             vd;
    logic [NWordsWidth-1:0] nwords;
  } writer_cmd_t;

  typedef enum logic [1:0] {
    WrIdle,
    WrBusy,
    WrDone
  } writer_state_e;

  // Truncation to the address width is what wraps v31 back to v0.
  function automatic vreg_addr_t word_addr(input logic [4:0] vd,
                                           input logic [NWordsWidth-1:0] cnt);
    return vreg_addr_t'(32'(vd) * NrWordsPerVreg) + vreg_addr_t'(cnt);
  endfunction

endpackage

// File: rtl/spatz_vrf_writer_fifo.sv
// Small power-of-two FIFO buffering result words (data + byte enables) for the writer.
// Interface mirrors common_cells fifo_v3: full/empty flags, head visible on data_o.
module spatz_vrf_writer_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrWidth = $clog2(Depth);
  localparam int unsigned CntWidth = $clog2(Depth + 1);

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrWidth-1:0] wptr_q, rptr_q;
  logic [CntWidth-1:0] cnt_q;
  logic                push_ok, pop_ok;

  assign full_o  = (cnt_q == CntWidth'(Depth));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rptr_q];

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/spatz_vrf_writer.sv
// Write-back requester for one spatz_vrf write port: buffers result words and issues
// one VRF write per word, holding each request until the bank arbiter grants it.
module spatz_vrf_writer
  import spatz_vrf_writer_pkg::*;
#(
  parameter int unsigned BufDepth = 2,
  parameter int unsigned IdWidth  = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [4:0]               cmd_vd_i,
  input  logic [NWordsWidth-1:0]   cmd_nwords_i,
  input  logic [IdWidth-1:0]       cmd_id_i,
  input  logic                     data_valid_i,
  output logic                     data_ready_o,
  input  logic [VregDataWidth-1:0] data_i,
  input  logic [VregBeWidth-1:0]   be_i,
  output logic [VregAddrWidth-1:0] waddr_o,
  output logic [VregDataWidth-1:0] wdata_o,
  output logic                     we_o,
  output logic [VregBeWidth-1:0]   wbe_o,
  input  logic                     wvalid_i,
  output logic                     done_o,
  output logic [IdWidth-1:0]       done_id_o
);

  localparam int unsigned FifoWidth = VregDataWidth + VregBeWidth;

  writer_state_e          state_q;
  writer_cmd_t            cmd_q;
  logic [IdWidth-1:0]     id_q;
  logic [NWordsWidth-1:0] word_cnt_q;

  logic [FifoWidth-1:0] fifo_head;
  logic                 fifo_full, fifo_empty;
  logic                 busy, grant;

  spatz_vrf_writer_fifo #(
    .Width (FifoWidth),
    .Depth (BufDepth)
  ) i_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (data_valid_i),
    .data_i  ({data_i, be_i}),
    .pop_i   (grant),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign busy         = (state_q == WrBusy);
  assign we_o         = busy & ~fifo_empty;
  assign grant        = we_o & wvalid_i;
  assign data_ready_o = ~fifo_full;
  assign cmd_ready_o  = (state_q == WrIdle);
  assign done_o       = (state_q == WrDone);
  assign done_id_o    = done_o ? id_q : '0;

  // Idle ports read as zero so a downstream mux sees a clean bus outside requests.
  assign waddr_o          = busy ? word_addr(cmd_q.vd, word_cnt_q) : '0;
  assign {wdata_o, wbe_o} = we_o ? fifo_head : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= WrIdle;
      cmd_q      <= '0;
      id_q       <= '0;
      word_cnt_q <= '0;
    end else begin
      unique case (state_q)
        WrIdle: begin
          if (cmd_valid_i) begin
            cmd_q      <= '{vd: cmd_vd_i, nwords: cmd_nwords_i};
            id_q       <= cmd_id_i;
            word_cnt_q <= '0;
            state_q    <= (cmd_nwords_i == '0) ? WrDone : WrBusy;
          end
        end
        WrBusy: begin
          if (grant) begin
            word_cnt_q <= word_cnt_q + 1'b1;
            if (word_cnt_q == cmd_q.nwords - 1'b1) state_q <= WrDone;
          end
        end
        WrDone:  state_q <= WrIdle;
        default: state_q <= WrIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spatz_vrf_writer.sv
// Directed bench for spatz_vrf_writer (NrWordsPerVreg=4, BufDepth=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_spatz_vrf_writer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [4:0]   cmd_vd;
  logic [5:0]   cmd_nwords;
  logic [2:0]   cmd_id;
  logic         data_valid;
  logic         data_ready;
  logic [127:0] data;
  logic [15:0]  be;
  logic [6:0]   waddr;
  logic [127:0] wdata;
  logic         we;
  logic [15:0]  wbe;
  logic         wvalid;
  logic         done;
  logic [2:0]   done_id;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spatz_vrf_writer #(
    .BufDepth (2),
    .IdWidth  (3)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_vd_i     (cmd_vd),
    .cmd_nwords_i (cmd_nwords),
    .cmd_id_i     (cmd_id),
    .data_valid_i (data_valid),
    .data_ready_o (data_ready),
    .data_i       (data),
    .be_i         (be),
    .waddr_o      (waddr),
    .wdata_o      (wdata),
    .we_o         (we),
    .wbe_o        (wbe),
    .wvalid_i     (wvalid),
    .done_o       (done),
    .done_id_o    (done_id)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] word_of(input int j);
    return {32'hC0DE_0000 + 32'(j), 32'h5A5A_0000 + 32'(j), ~32'(j), 32'(j * 3)};
  endfunction

  function automatic logic [15:0] be_of(input int j);
    return 16'hA5C3 ^ 16'(j * 'h0111);
  endfunction

  task automatic check_reset_outputs(input string name);
    check({name, " cmd_ready"},  128'(cmd_ready),  128'd1);
    check({name, " data_ready"}, 128'(data_ready), 128'd1);
    check({name, " we"},         128'(we),         128'd0);
    check({name, " waddr"},      128'(waddr),      128'd0);
    check({name, " wdata"},      wdata,            128'd0);
    check({name, " wbe"},        128'(wbe),        128'd0);
    check({name, " done"},       128'(done),       128'd0);
    check({name, " done_id"},    128'(done_id),    128'd0);
  endtask

  // Offers n words starting at index base whenever the FIFO has room; ends on a falling edge.
  task automatic push_words(input int base, input int n);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 200) begin
      guard++;
      if (data_ready) begin
        data_valid = 1'b1;
        data       = word_of(base + k);
        be         = be_of(base + k);
        k++;
      end else begin
        data_valid = 1'b0;
      end
      @(negedge clk);
    end
    data_valid = 1'b0;
    if (k < n) check("push timeout", 128'(k), 128'(n));
  endtask

  // Issues one command, feeds npush words, grants requests (with an optional stall) and
  // checks every request against the expected address/data and the completion pulse.
  task automatic run_cmd(input string name, input int vd, input int nwords, input int id,
                         input int npush, input int base, input int stall_word,
                         input int stall_cycles, input int abort_after);
    int  granted = 0;
    int  cycles  = 0;
    int  stalls  = 0;
    bit  fin     = 1'b0;
    check({name, " cmd_ready before"}, 128'(cmd_ready), 128'd1);
    cmd_valid  = 1'b1;
    cmd_vd     = 5'(vd);
    cmd_nwords = 6'(nwords);
    cmd_id     = 3'(id);
    fork
      push_words(base, npush);
      begin
        @(negedge clk);
        cmd_valid = 1'b0;
        while (!fin && cycles < 200) begin
          cycles++;
          if (abort_after >= 0 && granted == abort_after) begin
            #2 rst_n = 1'b0;
            #1 check_reset_outputs({name, " async reset"});
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            fin   = 1'b1;
          end else if (done) begin
            check($sformatf("%s done_id", name), 128'(done_id), 128'(id));
            check($sformatf("%s grants", name), 128'(granted), 128'(nwords));
            check($sformatf("%s turnaround", name), 128'(cycles),
                  128'(nwords + 1 + stall_cycles));
            fin = 1'b1;
          end else begin
            wvalid = 1'b1;
            if (we) begin
              check($sformatf("%s waddr[%0d]", name, granted), 128'(waddr),
                    128'((vd * 4 + granted) % 128));
              check($sformatf("%s wdata[%0d]", name, granted), wdata, word_of(base + granted));
              check($sformatf("%s wbe[%0d]", name, granted), 128'(wbe),
                    128'(be_of(base + granted)));
              if (granted == stall_word && stalls < stall_cycles) begin
                wvalid = 1'b0;
                stalls++;
                if (stalls == stall_cycles)
                  check($sformatf("%s data_ready full", name), 128'(data_ready), 128'd0);
              end else begin
                granted++;
              end
            end
            @(negedge clk);
          end
        end
        if (!fin) check({name, " timeout"}, 128'(cycles), 128'(nwords + 1));
        wvalid = 1'b1;
      end
    join
    @(negedge clk);
    check({name, " cmd_ready after"}, 128'(cmd_ready), 128'd1);
    check({name, " done cleared"},    128'(done),      128'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_vd     = '0;
    cmd_nwords = '0;
    cmd_id     = '0;
    data_valid = 1'b0;
    data       = '0;
    be         = '0;
    wvalid     = 1'b1;
    #3 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd("basic", 2, 4, 5, 4, 0, -1, 0, -1);
    run_cmd("stall", 2, 4, 3, 4, 10, 1, 3, -1);
    run_cmd("wrap", 31, 8, 7, 8, 20, -1, 0, -1);
    run_cmd("zero", 6, 0, 1, 0, 0, -1, 0, -1);
    check("zero no we", 128'(we), 128'd0);

    push_words(100, 2);
    check("prefill full", 128'(data_ready), 128'd0);
    run_cmd("prefill", 0, 2, 4, 0, 100, -1, 0, -1);

    run_cmd("abort", 2, 4, 6, 4, 40, -1, 0, 2);
    repeat (2) begin
      @(negedge clk);
      check("abort no done", 128'(done), 128'd0);
      check("abort fifo empty", 128'(we), 128'd0);
    end
    run_cmd("after reset", 4, 2, 2, 2, 200, -1, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spatz_vrf_writer.md
Name: spatz_vrf_writer

Overview:
- Write-side requester for one write port of spatz_vrf.
- Accepts a write-back command (destination vreg, word count) plus a stream of result words with byte enables, buffers them, and issues per-word VRF write requests.
- Holds each request stable until the VRF bank arbiter grants it (wvalid), then advances the word address and signals command completion.
- Instantiated per writer: VFU, VLSU and VSLDU write-back paths.

Parameters:
- BufDepth, 2, depth of the data/byte-enable FIFO (power of two, >=2)
- IdWidth, 3, width of the command tag returned on completion

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_vd_i  in  5  first destination vector register
- cmd_nwords_i  in  NWordsWidth  words to write (0..MaxWords)
- cmd_id_i  in  IdWidth  command tag
- data_valid_i  in  1  result word valid
- data_ready_o  out  1  FIFO can accept a word
- data_i  in  vreg_data_t  result word
- be_i  in  vreg_be_t  byte enables for data_i
- waddr_o  out  vreg_addr_t  VRF write address
- wdata_o  out  vreg_data_t  VRF write data
- we_o  out  1  write request
- wbe_o  out  vreg_be_t  write byte enables
- wvalid_i  in  1  grant from VRF arbiter, same cycle as request
- done_o  out  1  one-cycle completion pulse
- done_id_o  out  IdWidth  tag of the completed command

Behaviour:
- Reset values: cmd_ready_o=1, data_ready_o=1, we_o=0, waddr_o/wdata_o/wbe_o=0, done_o=0, done_id_o=0. FIFO empty, FSM IDLE, counters 0.
- Reset asserted mid-command discards buffered words and the active command. No done pulse is emitted.
- FSM IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i: latch vd, nwords, id.
  - nwords==0 -> go to DONE.
  - Otherwise -> go to BUSY with word counter=0.
- FSM BUSY:
  - cmd_ready_o=0.
  - we_o = !fifo_empty.
  - waddr_o = (vd*NrWordsPerVreg + word_cnt) mod (32*NrWordsPerVreg).
  - wdata_o/wbe_o = FIFO head.
- Address layout: the bank field occupies the vreg_addr_t LSBs, so consecutive words rotate banks. Commands longer than one vreg (LMUL>1) continue into vd+1, vd+2, ... and wrap from v31 to v0.
- Grant handling:
  - On we_o && wvalid_i: pop FIFO, word_cnt++.
  - If word_cnt == nwords-1 -> go to DONE.
  - Without a grant, request, address and data stay unchanged (stall). No timeout.
- FSM DONE: for one cycle done_o=1 and done_id_o=latched id; we_o=0; then -> IDLE. Minimum command turnaround is 1 + nwords + 1 cycles.
- FIFO:
  - data_ready_o = !fifo_full, in every state, so the next command's data may prefill.
  - No bypass: a word pushed in cycle t can be requested at t+1 at the earliest.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - Push while full is impossible because ready is low.
  - Words in excess of nwords stay buffered for the next command.
- wvalid_i is ignored when we_o=0.
- Arithmetic:
  - word_cnt and cmd_nwords_i are NWordsWidth bits.
  - Address math uses vreg_addr_t width and truncates, which gives the wrap.

Decomposition:
- spatz_pkg gains:
  - NrWordsPerVreg = VLEN/(N_IPU*ELEN)
  - MaxWords = 8*NrWordsPerVreg
  - NWordsWidth = $clog2(MaxWords+1)
  - a writer_cmd_t struct {vd, nwords, id}.
- vreg_addr_t, vreg_data_t and vreg_be_t are reused from the package.
- Buffer is the existing fifo_v3 (common_cells), DATA_WIDTH = data + be. No new sub-module.

Test Plan (config NrWordsPerVreg=4, BufDepth=2, wvalid_i tied 1 unless stated):
- Basic write:
  - Stimulus: cmd vd=2, nwords=4, id=5, then data words D0..D3 back-to-back.
  - Response: we_o on 4 consecutive cycles with waddr 8,9,10,11 and wdata D0..D3; done_o=1 with done_id_o=5 the cycle after the last grant.
- Stall under arbitration loss:
  - Stimulus: as above, but wvalid_i=0 for 3 cycles on word 1.
  - Response: waddr_o=9 and wdata_o=D1 held for those 3 cycles; data_ready_o=0 while the FIFO is full; no word lost or duplicated.
- Wrap across vregs:
  - Stimulus: vd=31, nwords=8.
  - Response: addresses 124..127 then 0..3; done after 8 grants.
- Zero length:
  - Stimulus: nwords=0, id=1.
  - Response: no we_o; done_o pulse with done_id_o=1 exactly 1 cycle after acceptance; cmd_ready_o high again the following cycle.
- Prefill:
  - Stimulus: 2 words pushed while IDLE, then cmd vd=0, nwords=2.
  - Response: we_o the cycle after acceptance with addresses 0 and 1 and the prefilled data.
- Reset mid-command:
  - Stimulus: rst_ni low after 2 of 4 grants.
  - Response: all outputs at reset values immediately (asynchronous); no done_o; a new command after reset starts at word 0 with an empty FIFO.
